tea_ptxt_packer: RTL and testbench

Upstream feeder for tiny_encryption_algorithm. Accepts a byte stream with a valid/ready handshake and assembles it into 64-bit plaintext blocks. Applies PKCS#7-style padding at end of message. Presents each block to the TEA core with one-cycle ptxt_valid/key_valid pulses, then waits for ctxt_ready before accepting the next block's bytes.

---
 rtl/tea_ptxt_packer.sv | 128 ++++++++++++
 tb/tb_tea_ptxt_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_ptxt_packer.sv
// Byte-stream to 64-bit TEA plaintext packer with PKCS#7 or zero padding.
// Issues one block at a time and waits for the core's ctxt_ready between blocks.
module tea_ptxt_packer #(
    parameter bit          PAD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             key_load,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [63:0]      ptxt,
    output logic [127:0]     key,
    output logic             ptxt_valid,
    output logic             key_valid,
    input  logic             ctxt_ready,
    output logic             busy,
    output logic             msg_done,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [2:0] {NOKEY, FILL, PAD, ISSUE, WAIT} state_t;

    state_t      state, state_d;
    logic [63:0] asm_q, asm_d;
    logic [3:0]  byte_cnt, byte_cnt_d;
    logic        pad_pend, pad_pend_d;
    logic        last_blk, last_blk_d;
    logic        done_d;
    logic        key_we;
    logic        xfer;
    logic [7:0]  pad_byte;

    assign din_ready  = (state == FILL);
    assign ptxt_valid = (state == ISSUE);
    assign key_valid  = (state == ISSUE);
    assign busy       = (state == PAD) || (state == ISSUE) || (state == WAIT);
    assign xfer       = din_valid && (state == FILL);
    assign pad_byte   = PAD_EN ? (8'd8 - {4'd0, byte_cnt}) : 8'h00;

    always_comb begin
        state_d    = state;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt;
        pad_pend_d = pad_pend;
        last_blk_d = last_blk;
        done_d     = 1'b0;
        key_we     = 1'b0;
        unique case (state)
            NOKEY: begin
                if (key_load) begin
                    key_we  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                key_we = key_load && (byte_cnt == 4'd0);
                if (xfer) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (32'(byte_cnt) == i) asm_d[8*(7-i) +: 8] = din;
                    end
                    byte_cnt_d = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd7) begin
                        // A full final block under PKCS#7 still owes a whole pad block.
                        state_d    = ISSUE;
                        pad_pend_d = din_last && PAD_EN;
                        last_blk_d = din_last && !PAD_EN;
                    end else if (din_last) begin
                        state_d    = PAD;
                        last_blk_d = 1'b1;
                    end
                end
            end
            PAD: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (pad_pend) asm_d[8*(7-i) +: 8] = 8'h08;
                    else if (32'(byte_cnt) <= i) asm_d[8*(7-i) +: 8] = pad_byte;
                end
                if (pad_pend) last_blk_d = 1'b1;
                pad_pend_d = 1'b0;
                state_d    = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ctxt_ready) begin
                    byte_cnt_d = 4'd0;
                    if (pad_pend) begin
                        state_d = PAD;
                    end else begin
                        done_d     = last_blk;
                        last_blk_d = 1'b0;
                        state_d    = FILL;
                    end
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    // ptxt is a separate copy of the assembly buffer so it stays stable until the next ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NOKEY;
            asm_q     <= '0;
            byte_cnt  <= '0;
            pad_pend  <= 1'b0;
            last_blk  <= 1'b0;
            msg_done  <= 1'b0;
            ptxt      <= '0;
            key       <= '0;
            blk_count <= '0;
        end else begin
            state    <= state_d;
            asm_q    <= asm_d;
            byte_cnt <= byte_cnt_d;
            pad_pend <= pad_pend_d;
            last_blk <= last_blk_d;
            msg_done <= done_d;
            if (key_we) key <= key_in;
            if (state_d == ISSUE) ptxt <= asm_d;
            if (state == ISSUE) blk_count <= blk_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tea_ptxt_packer.sv
// Bench for tea_ptxt_packer: one zero-fill and one PKCS#7 instance, driven in turn,
// checked against a message-level padding/blocking reference model.
module tb_tea_ptxt_packer;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] blk_q_t[$];

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic [7:0]   din;
    logic         din_valid, din_last, ctxt_ready;
    logic         sel;

    logic         z_ready, z_pv, z_kv, z_busy, z_done;
    logic         p_ready, p_pv, p_kv, p_busy, p_done;
    logic [63:0]  z_ptxt, p_ptxt;
    logic [127:0] z_key, p_key;
    logic [15:0]  z_cnt, p_cnt;

    logic         o_ready, o_pv, o_kv, o_busy, o_done;
    logic [63:0]  o_ptxt;
    logic [127:0] o_key;
    logic [15:0]  o_cnt;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    logic [127:0] key_exp;
    logic [15:0]  blk_exp;

    always #5 clk = ~clk;

    tea_ptxt_packer #(.PAD_EN(1'b0), .CNT_W(16)) u_zero (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load & ~sel),
        .din(din), .din_valid(din_valid & ~sel), .din_last(din_last), .din_ready(z_ready),
        .ptxt(z_ptxt), .key(z_key), .ptxt_valid(z_pv), .key_valid(z_kv),
        .ctxt_ready(ctxt_ready & ~sel), .busy(z_busy), .msg_done(z_done), .blk_count(z_cnt)
    );

    tea_ptxt_packer #(.PAD_EN(1'b1), .CNT_W(16)) u_pad (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load & sel),
        .din(din), .din_valid(din_valid & sel), .din_last(din_last), .din_ready(p_ready),
        .ptxt(p_ptxt), .key(p_key), .ptxt_valid(p_pv), .key_valid(p_kv),
        .ctxt_ready(ctxt_ready & sel), .busy(p_busy), .msg_done(p_done), .blk_count(p_cnt)
    );

    assign o_ready = sel ? p_ready : z_ready;
    assign o_pv    = sel ? p_pv    : z_pv;
    assign o_kv    = sel ? p_kv    : z_kv;
    assign o_busy  = sel ? p_busy  : z_busy;
    assign o_done  = sel ? p_done  : z_done;
    assign o_ptxt  = sel ? p_ptxt  : z_ptxt;
    assign o_key   = sel ? p_key   : z_key;
    assign o_cnt   = sel ? p_cnt   : z_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pad the whole message, then cut it into big-endian 64-bit words.
    function automatic blk_q_t ref_blocks(input byte_q_t msg, input logic pad);
        byte_q_t     p;
        blk_q_t      r;
        logic [63:0] w;
        int unsigned k;
        p = msg;
        if (pad) begin
            k = 8 - (msg.size() % 8);
            repeat (k) p.push_back(8'(k));
        end else begin
            while (p.size() % 8 != 0) p.push_back(8'h00);
        end
        for (int unsigned b = 0; b < p.size() / 8; b++) begin
            w = '0;
            for (int unsigned j = 0; j < 8; j++) w = {w[55:0], p[8*b+j]};
            r.push_back(w);
        end
        return r;
    endfunction

    function automatic byte_q_t from_word(input logic [63:0] w, input int unsigned n);
        byte_q_t     q;
        logic [63:0] t;
        t = w;
        for (int unsigned i = 0; i < n; i++) begin
            q.push_back(t[63:56]);
            t = t << 8;
        end
        return q;
    endfunction

    function automatic byte_q_t rand_msg(input int unsigned n);
        byte_q_t q;
        for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ptxt"},  o_ptxt,  '0);
        chk({tag, "_key"},   o_key,   '0);
        chk({tag, "_pv"},    o_pv,    '0);
        chk({tag, "_kv"},    o_kv,    '0);
        chk({tag, "_ready"}, o_ready, '0);
        chk({tag, "_busy"},  o_busy,  '0);
        chk({tag, "_done"},  o_done,  '0);
        chk({tag, "_cnt"},   o_cnt,   '0);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        key_exp  = k;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        int unsigned n;
        n         = 0;
        din       = b;
        din_last  = last;
        din_valid = 1'b1;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic run_msg(input byte_q_t msg, input int unsigned delay,
                           input int unsigned hold, input int kl_at);
        blk_q_t       blks;
        int unsigned  len, nb, lo, nbytes, n;
        logic [127:0] k;
        blks = ref_blocks(msg, sel);
        len  = msg.size();
        nb   = blks.size();
        for (int unsigned j = 0; j < nb; j++) begin
            lo     = 8 * j;
            nbytes = (len > lo) ? ((len - lo > 8) ? 8 : len - lo) : 0;
            if (nbytes > 0) begin
                for (int unsigned i = lo; i < lo + nbytes; i++) begin
                    if (kl_at >= 0 && int'(i) == kl_at) begin
                        k        = {$urandom, $urandom, $urandom, $urandom};
                        key_in   = k;
                        key_load = 1'b1;
                        repeat (3) @(posedge clk);
                        #1;
                        key_load = 1'b0;
                        if (i % 8 == 0) key_exp = k;
                    end
                    push_byte(msg[i], i == len - 1);
                end
                @(negedge clk);
            end
            n = 1;
            while (!o_pv && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("latency", n, (nbytes == 8) ? 2'd1 : 2'd2);
            chk("ptxt", o_ptxt, blks[j]);
            chk("key", o_key, key_exp);
            chk("key_valid", o_kv, 1'b1);
            chk("busy_issue", o_busy, 1'b1);
            @(negedge clk);
            blk_exp++;
            chk("strobe_width", o_pv, 1'b0);
            chk("blk_count", o_cnt, blk_exp);
            repeat (delay) @(negedge clk);
            chk("busy_wait", o_busy, 1'b1);
            chk("ptxt_hold", o_ptxt, blks[j]);
            ctxt_ready = 1'b1;
            @(negedge clk);
            chk("msg_done", o_done, j == nb - 1);
            chk("ready_after", o_ready, !((j + 1 < nb) && (8 * (j + 1) >= len)));
            if (j == nb - 1) begin
                repeat (hold - 1) begin
                    @(negedge clk);
                    chk("done_held", o_done, 1'b0);
                end
                ctxt_ready = 1'b0;
                @(negedge clk);
                chk("done_width", o_done, 1'b0);
                chk("blk_count_end", o_cnt, blk_exp);
            end else begin
                ctxt_ready = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0; key_in = '0; key_load = 1'b0; din = '0;
        din_valid = 1'b0; din_last = 1'b0; ctxt_ready = 1'b0; sel = 1'b0;
        key_exp = '0; blk_exp = '0;
        #12;
        check_idle("reset_z");
        sel = 1'b1;
        #1;
        check_idle("reset_p");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-fill instance
        din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("nokey_ready_z", o_ready, 1'b0);
        end
        din_valid = 1'b0;
        load_key(128'hACA648FF30F3A45F8AE8F6D9F6027C41);
        chk("key_ready_z", o_ready, 1'b1);
        run_msg(from_word(64'h18E529C5EF988A23, 8), 40, 1, -1);
        run_msg(from_word(64'h1100000000000000, 1), 3, 5, -1);
        run_msg(rand_msg(12), 5, 1, 3);
        for (int r = 0; r < 3; r++)
            run_msg(rand_msg($urandom_range(1, 20)), $urandom_range(1, 20), 1,
                    ($urandom_range(0, 1) == 1) ? 0 : -1);

        // PKCS#7 instance
        sel = 1'b1;
        key_exp = '0;
        blk_exp = '0;
        @(negedge clk);
        din_valid = 1'b1;
        key_load  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("nokey_ready_p", o_ready, 1'b0);
        end
        din_valid = 1'b0;
        load_key({$urandom, $urandom, $urandom, $urandom});
        run_msg(from_word(64'hAABBCC0000000000, 3), 7, 1, -1);
        run_msg(from_word(64'h0001020304050607, 8), 4, 1, -1);
        run_msg(rand_msg(16), 2, 1, 8);
        for (int r = 0; r < 3; r++)
            run_msg(rand_msg($urandom_range(1, 20)), $urandom_range(1, 20), 1,
                    ($urandom_range(0, 1) == 1) ? 0 : -1);

        // Asynchronous reset while waiting on the core
        for (int i = 0; i < 8; i++) push_byte(8'($urandom), 1'b0);
        n = 0;
        while (!o_pv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_strobe", o_pv, 1'b1);
        @(negedge clk);
        chk("pre_rst_busy", o_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rst_wait_p");
        sel = 1'b0;
        #1;
        check_idle("rst_wait_z");
        sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ctxt_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", o_done, 1'b0);
            chk("post_rst_cnt", o_cnt, 16'd0);
            chk("post_rst_busy", o_busy, 1'b0);
        end
        ctxt_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
